// File: rtl/grf_pkg.sv
// Shared defaults, types and helpers for the general-purpose register file.
package grf_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  // Upper bound on register file depth supported by popcount.
  localparam int unsigned MAX_DEPTH  = 1024;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
  typedef logic [DEF_DATA_W-1:0] reg_word_t;

  function automatic int unsigned popcount(input logic [MAX_DEPTH-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(MAX_DEPTH); i++) begin
      n += {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/grf_scoreboard.sv
// Busy scoreboard: one bit per register, issue sets, writeback clears, issue wins on conflict.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NWRITE   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic [NWRITE-1:0]        wr_en,
  input  logic [NWRITE*ADDR_W-1:0] wr_addr,
  output logic [(1<<ADDR_W)-1:0]   busy,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DEPTH-1:0]     busy_q, busy_d;
  logic [CNT_W-1:0]     busy_cnt_q, busy_cnt_d;
  logic [MAX_DEPTH-1:0] busy_ext;
  logic                 clr;

  always_comb begin
    busy_d = busy_q;
    clr    = 1'b0;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      clr = 1'b0;
      for (int unsigned k = 0; k < NWRITE; k++) begin
        if (wr_en[k] && wr_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(r)) clr = 1'b1;
      end
      // A new producer issued while the old one retires keeps the register busy.
      if (iss_en && iss_addr == ADDR_W'(r)) begin
        busy_d[r] = 1'b1;
      end else if (clr) begin
        busy_d[r] = 1'b0;
      end
    end
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  // Count the next-state vector so the count moves on the same edge as the bits.
  always_comb begin
    busy_ext             = '0;
    busy_ext[DEPTH-1:0]  = busy_d;
    busy_cnt_d           = CNT_W'(popcount(busy_ext));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy     = busy_q;
  assign busy_cnt = busy_cnt_q;

endmodule

// File: rtl/grf_multiport.sv
// Multi-port register file with integrated busy scoreboard.
// Define GRF_BYPASS_EN to forward same-cycle write data to the read ports.
module grf_multiport
  import grf_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NREAD    = 2,
  parameter int unsigned NWRITE   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREAD*ADDR_W-1:0]  rd_addr,
  output logic [NREAD*DATA_W-1:0]  rd_data,
  output logic [NREAD-1:0]         rd_busy,
  input  logic [NWRITE-1:0]        wr_en,
  input  logic [NWRITE*ADDR_W-1:0] wr_addr,
  input  logic [NWRITE*DATA_W-1:0] wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic [ADDR_W-1:0] wa;
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rdat;
  logic              rbusy;
`ifdef GRF_BYPASS_EN
  logic              hit;
`endif

  grf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NWRITE   (NWRITE),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  // Ascending port order: the highest-numbered port's write lands last and wins.
  always_comb begin
    regs_d = regs_q;
    wa     = '0;
    for (int unsigned k = 0; k < NWRITE; k++) begin
      wa = wr_addr[k*ADDR_W +: ADDR_W];
      if (wr_en[k] && !(ZERO_REG != 0 && wa == '0)) begin
        regs_d[wa] = wr_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    rdat    = '0;
    rbusy   = 1'b0;
`ifdef GRF_BYPASS_EN
    hit     = 1'b0;
`endif
    for (int unsigned i = 0; i < NREAD; i++) begin
      ra    = rd_addr[i*ADDR_W +: ADDR_W];
      rdat  = regs_q[ra];
      rbusy = busy[ra];
`ifdef GRF_BYPASS_EN
      hit = 1'b0;
      for (int unsigned k = 0; k < NWRITE; k++) begin
        if (wr_en[k] && wr_addr[k*ADDR_W +: ADDR_W] == ra) begin
          hit  = 1'b1;
          rdat = wr_data[k*DATA_W +: DATA_W];
        end
      end
      // Forwarded value is complete unless a new producer is issuing to it now.
      if (hit && !(iss_en && iss_addr == ra)) rbusy = 1'b0;
`endif
      if ((ZERO_REG != 0 && ra == '0) || reset) begin
        rdat  = '0;
        rbusy = 1'b0;
      end
      rd_data[i*DATA_W +: DATA_W] = rdat;
      rd_busy[i]                  = rbusy;
    end
  end

endmodule

// File: tb/tb_grf_multiport.sv
// Self-checking bench for grf_multiport (NWRITE=2); adapts to GRF_BYPASS_EN when defined.
module tb_grf_multiport;
  import grf_pkg::*;

`ifdef GRF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        iss_en;
  reg_idx_t    iss_addr;
  logic [5:0]  busy_cnt;

  grf_multiport #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .NREAD    (2),
    .NWRITE   (2),
    .ZERO_REG (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_cnt (busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] we;
    reg_idx_t   wa0;
    reg_word_t  wd0;
    reg_idx_t   wa1;
    reg_word_t  wd1;
    logic       ie;
    reg_idx_t   ia;
    reg_idx_t   ra0;
    reg_idx_t   ra1;
    reg_word_t  d0;
    logic       b0;
    reg_word_t  d1;
    logic       b1;
    logic [5:0] cnt;
  } vec_t;

  typedef struct {
    reg_word_t  d0;
    logic       b0;
    reg_word_t  d1;
    logic       b1;
    logic [5:0] cnt;
  } exp_t;

  vec_t vecs [11];
  exp_t exp_q [$];
  exp_t e;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic idle();
    wr_en  = 2'b00;
    iss_en = 1'b0;
  endtask

  function automatic vec_t mk(logic [1:0] we, reg_idx_t wa0, reg_word_t wd0, reg_idx_t wa1,
                              reg_word_t wd1, logic ie, reg_idx_t ia, reg_idx_t ra0,
                              reg_idx_t ra1, reg_word_t d0, logic b0, reg_word_t d1,
                              logic b1, logic [5:0] cnt);
    vec_t v;
    v.we = we;   v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ie = ie;   v.ia = ia;   v.ra0 = ra0; v.ra1 = ra1;
    v.d0 = d0;   v.b0 = b0;   v.d1 = d1;   v.b1 = b1;   v.cnt = cnt;
    return v;
  endfunction

  initial begin
    //            we     wa0 wd0            wa1 wd1   ie ia  ra0 ra1 d0            b0 d1            b1 cnt
    vecs[0]  = mk(2'b01, 5,  32'h0BAD_F00D, 0,  0,    0, 0,  5,  0,  32'h0BAD_F00D, 0, 0,             0, 0);
    vecs[1]  = mk(2'b01, 0,  32'h1234,      0,  0,    1, 0,  0,  5,  0,             0, 32'h0BAD_F00D, 0, 0);
    vecs[2]  = mk(2'b11, 7,  1,             7,  2,    0, 0,  7,  5,  2,             0, 32'h0BAD_F00D, 0, 0);
    vecs[3]  = mk(2'b00, 0,  0,             0,  0,    1, 3,  3,  7,  0,             1, 2,             0, 1);
    vecs[4]  = mk(2'b01, 3,  32'hAAAA,      0,  0,    1, 3,  3,  3,  32'hAAAA,      1, 32'hAAAA,      1, 1);
    vecs[5]  = mk(2'b10, 0,  0,             3,  32'hBBBB, 0, 0, 3, 0, 32'hBBBB,     0, 0,             0, 0);
    vecs[6]  = mk(2'b01, 10, 32'h55,        0,  0,    1, 9,  9,  10, 0,             1, 32'h55,        0, 1);
    vecs[7]  = mk(2'b10, 0,  0,             9,  32'h66, 1, 10, 9, 10, 32'h66,      0, 32'h55,        1, 1);
    vecs[8]  = mk(2'b00, 0,  0,             0,  0,    1, 10, 10, 31, 32'h55,        1, 0,             0, 1);
    vecs[9]  = mk(2'b11, 31, 32'hFFFF_FFFF, 30, 1,    0, 0,  31, 30, 32'hFFFF_FFFF, 0, 1,             0, 1);
    vecs[10] = mk(2'b01, 10, 32'h77,        0,  0,    0, 0,  10, 7,  32'h77,        0, 2,             0, 0);

    reset = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0; iss_en = 1'b0; iss_addr = '0;
    rd_addr = {5'd3, 5'd5};
    #2;
    chk("reset_rd_data", rd_data, 64'h0);
    chk("reset_rd_busy", {62'b0, rd_busy}, 64'h0);
    chk("reset_busy_cnt", {58'b0, busy_cnt}, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    // Same-cycle write then read of r5.
    @(negedge clk);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEAD_BEEF}; rd_addr = {5'd0, 5'd5};
    #1 chk("wr_same_cycle", {32'h0, rd_data[31:0]}, BYP ? 64'hDEAD_BEEF : 64'h0);
    @(posedge clk); #1 idle();
    #1 chk("wr_next_cycle", {32'h0, rd_data[31:0]}, 64'hDEAD_BEEF);

    // Busy masking around a same-cycle write.
    @(negedge clk);
    iss_en = 1'b1; iss_addr = 5'd12; rd_addr = {5'd0, 5'd12};
    @(posedge clk); #1 idle();
    #1 chk("iss12_busy", {63'b0, rd_busy[0]}, 64'h1);
    @(negedge clk);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd12}; wr_data = {32'h0, 32'h12};
    #1 chk("wr12_busy_mask", {63'b0, rd_busy[0]}, BYP ? 64'h0 : 64'h1);
    chk("wr12_data_fwd", {32'h0, rd_data[31:0]}, BYP ? 64'h12 : 64'h0);
    iss_en = 1'b1; iss_addr = 5'd12;
    #1 chk("wr12_iss_busy", {63'b0, rd_busy[0]}, 64'h1);
    @(posedge clk); #1 idle();
    #1 chk("wr12_iss_hold", {63'b0, rd_busy[0]}, 64'h1);
    chk("wr12_iss_cnt", {58'b0, busy_cnt}, 64'h1);
    @(negedge clk);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd12}; wr_data = {32'h0, 32'h13};
    @(posedge clk); #1 idle();
    #1 chk("wr12_clear_cnt", {58'b0, busy_cnt}, 64'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      wr_en    = vecs[i].we;
      wr_addr  = {vecs[i].wa1, vecs[i].wa0};
      wr_data  = {vecs[i].wd1, vecs[i].wd0};
      iss_en   = vecs[i].ie;
      iss_addr = vecs[i].ia;
      rd_addr  = {vecs[i].ra1, vecs[i].ra0};
      exp_q.push_back('{d0: vecs[i].d0, b0: vecs[i].b0, d1: vecs[i].d1, b1: vecs[i].b1,
                        cnt: vecs[i].cnt});
      @(posedge clk); #1 idle();
      #1;
      if (exp_q.size() == 0) begin
        chk($sformatf("v%0d_queue", i), 64'h0, 64'h1);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("v%0d_d0", i), {32'h0, rd_data[31:0]}, {32'h0, e.d0});
        chk($sformatf("v%0d_b0", i), {63'b0, rd_busy[0]}, {63'b0, e.b0});
        chk($sformatf("v%0d_d1", i), {32'h0, rd_data[63:32]}, {32'h0, e.d1});
        chk($sformatf("v%0d_b1", i), {63'b0, rd_busy[1]}, {63'b0, e.b1});
        chk($sformatf("v%0d_cnt", i), {58'b0, busy_cnt}, {58'b0, e.cnt});
      end
    end

    // Fill every nonzero register.
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      iss_en = 1'b1; iss_addr = 5'(r);
      @(posedge clk); #1 idle();
    end
    rd_addr = {5'd31, 5'd1};
    #1 chk("fill_cnt", {58'b0, busy_cnt}, 64'd31);
    chk("fill_busy", {62'b0, rd_busy}, 64'h3);
    @(negedge clk);
    iss_en = 1'b1; iss_addr = 5'd0; rd_addr = {5'd31, 5'd0};
    @(posedge clk); #1 idle();
    #1 chk("fill_r0_cnt", {58'b0, busy_cnt}, 64'd31);
    chk("fill_r0_busy", {63'b0, rd_busy[0]}, 64'h0);

    // Reset between edges clears everything at once.
    rd_addr = {5'd10, 5'd31};
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("midreset_cnt", {58'b0, busy_cnt}, 64'h0);
    chk("midreset_busy", {62'b0, rd_busy}, 64'h0);
    chk("midreset_data", rd_data, 64'h0);

    // Reset held across an edge overrides write and issue.
    wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h44};
    iss_en = 1'b1; iss_addr = 5'd4; rd_addr = {5'd0, 5'd4};
    @(posedge clk); #1 idle();
    reset = 1'b0;
    #1 chk("rst_override_data", {32'h0, rd_data[31:0]}, 64'h0);
    chk("rst_override_busy", {63'b0, rd_busy[0]}, 64'h0);
    chk("rst_override_cnt", {58'b0, busy_cnt}, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
